verificador_senha: RTL and testbench



---
 rtl/verificador_senha_pkg.sv | 33 +++
 rtl/verificador_senha_if.sv | 40 ++++
 rtl/verificador_senha_comparador_digito.sv | 16 +
 rtl/verificador_senha.sv | 193 +++++++++++++++++++
 tb/tb_verificador_senha.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/verificador_senha_pkg.sv
// Shared types and width helpers for the serial password checker.
package verificador_senha_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_LOCKED
    } state_e;

    typedef enum logic [1:0] {
        CMP_EQ,
        CMP_LT,
        CMP_GT
    } cmp_e;

    // Bits needed to hold the values 0..max_val (at least one bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int idx_width(input int n_digits);
        return cnt_w(n_digits);
    endfunction

    function automatic int tries_width(input int max_tries);
        return cnt_w(max_tries);
    endfunction

    function automatic int lock_width(input int lock_cycles);
        return cnt_w(lock_cycles);
    endfunction

endpackage

// File: rtl/verificador_senha_if.sv
// Keypad-side entry strobes and result/status signals of the password checker.
interface verificador_senha_if #(
    parameter int DIGIT_W   = 4,
    parameter int N_DIGITS  = 4,
    parameter int MAX_TRIES = 3
);
    import verificador_senha_pkg::*;

    localparam int IDX_W = idx_width(N_DIGITS);
    localparam int TRY_W = tries_width(MAX_TRIES);

    logic               digit_valid;
    logic [DIGIT_W-1:0] digit;
    logic               prog;
    logic               clear;
    logic               entry_busy;
    logic [IDX_W-1:0]   digit_idx;
    logic               result_valid;
    logic               altb;
    logic               aeqb;
    logic               agtb;
    logic               unlocked;
    logic               fail;
    logic               prog_done;
    logic               locked;
    logic [TRY_W-1:0]   tries_left;

    modport master (
        output digit_valid, digit, prog, clear,
        input  entry_busy, digit_idx, result_valid, altb, aeqb, agtb,
               unlocked, fail, prog_done, locked, tries_left
    );

    modport slave (
        input  digit_valid, digit, prog, clear,
        output entry_busy, digit_idx, result_valid, altb, aeqb, agtb,
               unlocked, fail, prog_done, locked, tries_left
    );

endinterface

// File: rtl/verificador_senha_comparador_digito.sv
// Combinational unsigned comparator for one digit; reused serially by the checker.
module comparador_digito #(
    parameter int DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] a_i,
    input  logic [DIGIT_W-1:0] b_i,
    output logic               lt_o,
    output logic               eq_o,
    output logic               gt_o
);

    assign lt_o = (a_i <  b_i);
    assign eq_o = (a_i == b_i);
    assign gt_o = (a_i >  b_i);

endmodule

// File: rtl/verificador_senha.sv
// Serial password checker: digit-by-digit compare, code programming, attempt count and lockout.
module verificador_senha #(
    parameter int DIGIT_W     = 4,
    parameter int N_DIGITS    = 4,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    verificador_senha_if.slave bus
);
    import verificador_senha_pkg::*;

    localparam int IDX_W  = idx_width(N_DIGITS);
    localparam int TRY_W  = tries_width(MAX_TRIES);
    localparam int LCK_W  = lock_width(LOCK_CYCLES);
    localparam int CODE_W = DIGIT_W * N_DIGITS;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_DIGITS - 1);
    localparam logic [TRY_W-1:0] TRIES_MAX = TRY_W'(MAX_TRIES);
    localparam logic [LCK_W-1:0] LOCK_LOAD = LCK_W'(LOCK_CYCLES - 1);

    state_e             state_q, state_d;
    cmp_e               cmp_q, cmp_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               mode_q, mode_d;
    logic [CODE_W-1:0]  staging_q, staging_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic               altb_q, altb_d, aeqb_q, aeqb_d, agtb_q, agtb_d;
    logic               rv_q, rv_d, unl_q, unl_d, fail_q, fail_d, pd_q, pd_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic [LCK_W-1:0]   lock_cnt_q, lock_cnt_d;

    logic [DIGIT_W-1:0] code_slice;
    logic               dig_lt, dig_eq, dig_gt;
    logic               accept, first, mode_cur;
    cmp_e               cmp_cur, cmp_step;
    logic [CODE_W-1:0]  staging_step;

    // Stored digit facing entry position idx_q (MSD first).
    assign code_slice = DIGIT_W'(code_q >> (DIGIT_W * (N_DIGITS - 1 - int'(idx_q))));

    comparador_digito #(.DIGIT_W(DIGIT_W)) u_cmp (
        .a_i  (bus.digit),
        .b_i  (code_slice),
        .lt_o (dig_lt),
        .eq_o (dig_eq),
        .gt_o (dig_gt)
    );

    always_comb begin
        accept   = bus.digit_valid && !bus.clear && (state_q != ST_LOCKED);
        first    = (idx_q == '0);
        mode_cur = first ? bus.prog : mode_q;
        cmp_cur  = first ? CMP_EQ : cmp_q;

        cmp_step = cmp_cur;
        if (cmp_cur == CMP_EQ) begin
            case ({dig_lt, dig_eq, dig_gt})
                3'b100:  cmp_step = CMP_LT;
                3'b001:  cmp_step = CMP_GT;
                default: cmp_step = CMP_EQ;
            endcase
        end

        staging_step = first ? CODE_W'(bus.digit)
                             : ((staging_q << DIGIT_W) | CODE_W'(bus.digit));
    end

    always_comb begin
        state_d    = state_q;
        cmp_d      = cmp_q;
        idx_d      = idx_q;
        mode_d     = mode_q;
        staging_d  = staging_q;
        code_d     = code_q;
        altb_d     = altb_q;
        aeqb_d     = aeqb_q;
        agtb_d     = agtb_q;
        tries_d    = tries_q;
        lock_cnt_d = lock_cnt_q;
        rv_d       = 1'b0;
        unl_d      = 1'b0;
        fail_d     = 1'b0;
        pd_d       = 1'b0;

        case (state_q)
            ST_IDLE, ST_ENTRY: begin
                if (state_q == ST_ENTRY && bus.clear) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else if (accept) begin
                    if (first) begin
                        altb_d = 1'b0;
                        aeqb_d = 1'b0;
                        agtb_d = 1'b0;
                        mode_d = bus.prog;
                    end
                    cmp_d     = cmp_step;
                    staging_d = staging_step;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                        if (mode_cur) begin
                            code_d = staging_step;
                            pd_d   = 1'b1;
                            altb_d = 1'b0;
                            aeqb_d = 1'b0;
                            agtb_d = 1'b0;
                        end else begin
                            rv_d   = 1'b1;
                            altb_d = (cmp_step == CMP_LT);
                            aeqb_d = (cmp_step == CMP_EQ);
                            agtb_d = (cmp_step == CMP_GT);
                            if (cmp_step == CMP_EQ) begin
                                unl_d   = 1'b1;
                                tries_d = TRIES_MAX;
                            end else begin
                                fail_d  = 1'b1;
                                tries_d = tries_q - TRY_W'(1);
                                if (tries_q == TRY_W'(1)) begin
                                    state_d    = ST_LOCKED;
                                    lock_cnt_d = LOCK_LOAD;
                                end
                            end
                        end
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_ENTRY;
                    end
                end
            end
            ST_LOCKED: begin
                if (lock_cnt_q == '0) begin
                    state_d = ST_IDLE;
                    tries_d = TRIES_MAX;
                end else begin
                    lock_cnt_d = lock_cnt_q - LCK_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cmp_q      <= CMP_EQ;
            idx_q      <= '0;
            mode_q     <= 1'b0;
            staging_q  <= '0;
            code_q     <= '0;
            altb_q     <= 1'b0;
            aeqb_q     <= 1'b0;
            agtb_q     <= 1'b0;
            rv_q       <= 1'b0;
            unl_q      <= 1'b0;
            fail_q     <= 1'b0;
            pd_q       <= 1'b0;
            tries_q    <= TRIES_MAX;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cmp_q      <= cmp_d;
            idx_q      <= idx_d;
            mode_q     <= mode_d;
            staging_q  <= staging_d;
            code_q     <= code_d;
            altb_q     <= altb_d;
            aeqb_q     <= aeqb_d;
            agtb_q     <= agtb_d;
            rv_q       <= rv_d;
            unl_q      <= unl_d;
            fail_q     <= fail_d;
            pd_q       <= pd_d;
            tries_q    <= tries_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign bus.entry_busy   = (state_q == ST_ENTRY);
    assign bus.digit_idx    = idx_q;
    assign bus.result_valid = rv_q;
    assign bus.altb         = altb_q;
    assign bus.aeqb         = aeqb_q;
    assign bus.agtb         = agtb_q;
    assign bus.unlocked     = unl_q;
    assign bus.fail         = fail_q;
    assign bus.prog_done    = pd_q;
    assign bus.locked       = (state_q == ST_LOCKED);
    assign bus.tries_left   = tries_q;

endmodule

// File: tb/tb_verificador_senha.sv
// Bench for verificador_senha: directed plan plus random entries against a numeric reference model.
module tb_verificador_senha;

    localparam int DW = 4;
    localparam int ND = 4;
    localparam int MT = 3;
    localparam int LC = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    verificador_senha_if #(.DIGIT_W(DW), .N_DIGITS(ND), .MAX_TRIES(MT)) bus ();

    verificador_senha #(
        .DIGIT_W(DW), .N_DIGITS(ND), .MAX_TRIES(MT), .LOCK_CYCLES(LC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int code_m [ND];
    int tries_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_digit(input int d, input logic p, input logic clr);
        bus.digit_valid = 1'b1;
        bus.digit       = DW'(d);
        bus.prog        = p;
        bus.clear       = clr;
        tick();
        bus.digit_valid = 1'b0;
        bus.clear       = 1'b0;
        bus.prog        = 1'b0;
    endtask

    // Entered and stored codes are compared as plain base-2^DW numbers.
    function automatic int code_val(input int ds [ND]);
        int v = 0;
        for (int i = 0; i < ND; i++) v = v * (1 << DW) + ds[i];
        return v;
    endfunction

    task automatic do_reset();
        bus.digit_valid = 1'b0;
        bus.clear       = 1'b0;
        bus.prog        = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < ND; i++) code_m[i] = 0;
        tries_m = MT;
        check("rst_busy",  32'(bus.entry_busy), 0);
        check("rst_idx",   32'(bus.digit_idx), 0);
        check("rst_pulse", 32'({bus.result_valid, bus.unlocked, bus.fail, bus.prog_done}), 0);
        check("rst_flags", 32'({bus.altb, bus.aeqb, bus.agtb}), 0);
        check("rst_lock",  32'(bus.locked), 0);
        check("rst_tries", 32'(bus.tries_left), MT);
    endtask

    task automatic check_lock();
        int n = 0;
        while (bus.locked && n < LC + 4) begin
            n++;
            bus.digit_valid = 1'b1;
            bus.digit       = DW'($urandom_range(15));
            bus.clear       = 1'($urandom_range(1));
            tick();
            bus.digit_valid = 1'b0;
            bus.clear       = 1'b0;
            check("lock_idx",   32'(bus.digit_idx), 0);
            check("lock_pulse", 32'({bus.result_valid, bus.unlocked, bus.fail, bus.prog_done}), 0);
        end
        check("lock_len", 32'(n), LC);
        tries_m = MT;
        check("lock_tries", 32'(bus.tries_left), MT);
        check("lock_drop",  32'(bus.locked), 0);
    endtask

    task automatic do_verify(input int ds [ND], input bit run_lock, input bit b2b);
        int ent, st;
        int sd [ND];
        for (int k = 0; k < ND; k++) begin
            drive_digit(ds[k], (k == 0) ? 1'b0 : 1'($urandom_range(1)), 1'b0);
            if (k == 0) check("v_flagclr", 32'({bus.altb, bus.aeqb, bus.agtb}), 0);
            if (k < ND - 1) begin
                check("v_idx",  32'(bus.digit_idx), 32'(k + 1));
                check("v_busy", 32'(bus.entry_busy), 1);
            end
        end
        sd  = code_m;
        ent = code_val(ds);
        st  = code_val(sd);
        if (ent == st) tries_m = MT;
        else           tries_m = tries_m - 1;
        check("v_rv",    32'(bus.result_valid), 1);
        check("v_altb",  32'(bus.altb), 32'(ent < st));
        check("v_aeqb",  32'(bus.aeqb), 32'(ent == st));
        check("v_agtb",  32'(bus.agtb), 32'(ent > st));
        check("v_unl",   32'(bus.unlocked), 32'(ent == st));
        check("v_fail",  32'(bus.fail), 32'(ent != st));
        check("v_pd",    32'(bus.prog_done), 0);
        check("v_tries", 32'(bus.tries_left), 32'(tries_m));
        check("v_lock",  32'(bus.locked), 32'(tries_m == 0));
        check("v_idx0",  32'(bus.digit_idx), 0);
        check("v_busy0", 32'(bus.entry_busy), 0);
        if (tries_m == 0) begin
            if (run_lock) check_lock();
        end else if (!b2b) begin
            tick();
            check("v_pulse_drop", 32'({bus.result_valid, bus.unlocked, bus.fail}), 0);
            check("v_hold", 32'(bus.aeqb), 32'(ent == st));
        end
    endtask

    task automatic do_prog(input int ds [ND]);
        for (int k = 0; k < ND; k++) begin
            drive_digit(ds[k], (k == 0) ? 1'b1 : 1'($urandom_range(1)), 1'b0);
            if (k < ND - 1) check("p_idx", 32'(bus.digit_idx), 32'(k + 1));
        end
        check("p_pd",    32'(bus.prog_done), 1);
        check("p_rv",    32'(bus.result_valid), 0);
        check("p_flags", 32'({bus.altb, bus.aeqb, bus.agtb}), 0);
        check("p_tries", 32'(bus.tries_left), 32'(tries_m));
        check("p_idx0",  32'(bus.digit_idx), 0);
        code_m = ds;
        tick();
        check("p_pd_drop", 32'(bus.prog_done), 0);
    endtask

    task automatic partial_clear(input int n);
        for (int k = 0; k < n; k++) drive_digit($urandom_range(15), 1'($urandom_range(1)), 1'b0);
        check("pc_idx", 32'(bus.digit_idx), 32'(n));
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("pc_idx0",  32'(bus.digit_idx), 0);
        check("pc_busy",  32'(bus.entry_busy), 0);
        check("pc_tries", 32'(bus.tries_left), 32'(tries_m));
        check("pc_pulse", 32'({bus.result_valid, bus.unlocked, bus.fail, bus.prog_done}), 0);
    endtask

    initial begin
        int rd [ND];
        int r;
        bus.digit_valid = 1'b0;
        bus.digit       = '0;
        bus.prog        = 1'b0;
        bus.clear       = 1'b0;
        rst = 1'b1;
        tick();
        do_reset();

        do_verify('{0, 0, 0, 0}, 1'b1, 1'b0);
        do_prog('{1, 2, 3, 4});
        do_verify('{1, 2, 3, 4}, 1'b1, 1'b0);
        do_verify('{1, 2, 4, 0}, 1'b1, 1'b0);
        do_verify('{1, 1, 9, 9}, 1'b1, 1'b0);
        do_verify('{0, 0, 0, 0}, 1'b1, 1'b0);
        do_verify('{1, 2, 3, 4}, 1'b1, 1'b0);

        partial_clear(2);
        drive_digit(5, 1'b0, 1'b1);
        check("cdv_idle_idx", 32'(bus.digit_idx), 0);
        check("cdv_idle_busy", 32'(bus.entry_busy), 0);
        drive_digit(1, 1'b0, 1'b0);
        drive_digit(5, 1'b0, 1'b1);
        check("cdv_entry_idx", 32'(bus.digit_idx), 0);
        do_verify('{1, 2, 3, 4}, 1'b1, 1'b0);

        drive_digit(1, 1'b0, 1'b0);
        drive_digit(2, 1'b0, 1'b0);
        do_reset();
        do_verify('{0, 0, 0, 0}, 1'b1, 1'b0);

        do_verify('{1, 0, 0, 0}, 1'b0, 1'b0);
        do_verify('{0, 0, 0, 7}, 1'b0, 1'b0);
        do_verify('{15, 15, 15, 15}, 1'b0, 1'b0);
        tick();
        tick();
        check("mid_lock", 32'(bus.locked), 1);
        do_reset();
        do_verify('{0, 0, 0, 0}, 1'b1, 1'b0);

        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(9);
            for (int i = 0; i < ND; i++) rd[i] = $urandom_range(15);
            if (r == 0) begin
                do_prog(rd);
            end else if (r <= 2) begin
                partial_clear($urandom_range(1, ND - 1));
            end else if (r <= 5) begin
                do_verify(code_m, 1'b1, 1'($urandom_range(1)));
            end else begin
                if (r == 6) rd[ND-1] = code_m[ND-1];
                do_verify(rd, 1'b1, 1'($urandom_range(1)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
